// File: rtl/ics_sample_server_if.sv
// Fetch-port and SDRAM read-channel bundle for the ICS2115 sample server.
// The slave side is the server; the master side is the audio core and the SDRAM model.
interface ics_sample_server_if;
  logic        req_rd;
  logic [28:0] req_addr;
  logic [63:0] rsp_data;
  logic        rsp_ready;
  logic        rsp_busy;
  logic        mem_req;
  logic [28:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        cache_inv;
  logic        timeout_err;

  modport slave (
    input  req_rd, req_addr, mem_ack, mem_rdata, mem_rvalid, cache_inv,
    output rsp_data, rsp_ready, rsp_busy, mem_req, mem_addr, timeout_err
  );

  modport master (
    output req_rd, req_addr, mem_ack, mem_rdata, mem_rvalid, cache_inv,
    input  rsp_data, rsp_ready, rsp_busy, mem_req, mem_addr, timeout_err
  );
endinterface

// File: rtl/ics_sample_server.sv
// ICS2115 sample-fetch responder: one-word cache in front of an SDRAM read channel,
// with a bounded wait on read data and a sticky timeout flag.
module ics_sample_server #(
  parameter logic [28:0] BASE_ADDR      = 29'h0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  ics_sample_server_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  state_e           state_q,       state_d;
  logic [25:0]      tag_q,         tag_d;
  logic [25:0]      cache_tag_q,   cache_tag_d;
  logic [63:0]      cache_data_q,  cache_data_d;
  logic             cache_valid_q, cache_valid_d;
  logic [63:0]      rsp_data_q,    rsp_data_d;
  logic             rsp_ready_q,   rsp_ready_d;
  logic             rsp_busy_q,    rsp_busy_d;
  logic             mem_req_q,     mem_req_d;
  logic [28:0]      mem_addr_q,    mem_addr_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             fill_s;
  logic             hit_s;

  // A hit needs a valid entry with a matching word tag and no invalidate in the same cycle.
  assign hit_s = cache_valid_q && (cache_tag_q == bus.req_addr[28:3]) && !bus.cache_inv;

  // Next-state and next-output logic for the request/fill sequencer.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    rsp_data_d    = rsp_data_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    fill_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_rd) begin
          tag_d = bus.req_addr[28:3];
          if (hit_s) begin
            rsp_data_d = cache_data_q;
            state_d    = ST_RESP;
          end else begin
            mem_addr_d = BASE_ADDR + {bus.req_addr[28:3], 3'b000};
            mem_req_d  = 1'b1;
            state_d    = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          rsp_data_d   = bus.mem_rdata;
          cache_data_d = bus.mem_rdata;
          cache_tag_d  = tag_q;
          fill_s       = 1'b1;
          state_d      = ST_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CNT_LAST) begin
            rsp_data_d    = 64'h0;
            timeout_err_d = 1'b1;
            state_d       = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.req_rd) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An invalidate always wins over a fill landing in the same cycle.
    cache_valid_d = bus.cache_inv ? 1'b0 : (fill_s ? 1'b1 : cache_valid_q);
    rsp_ready_d   = (state_d == ST_RESP);
    rsp_busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tag_q         <= 26'h0;
      cache_tag_q   <= 26'h0;
      cache_data_q  <= 64'h0;
      cache_valid_q <= 1'b0;
      rsp_data_q    <= 64'h0;
      rsp_ready_q   <= 1'b0;
      rsp_busy_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 29'h0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      cache_valid_q <= cache_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ready_q   <= rsp_ready_d;
      rsp_busy_q    <= rsp_busy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_ready   = rsp_ready_q;
  assign bus.rsp_busy    = rsp_busy_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ics_sample_server.sv
// Directed bench for ics_sample_server: miss/hit, offset wrap, timeout, invalidate,
// held request and reset mid-transaction.
module tb_ics_sample_server;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   rdy_cnt;
  int   memreq_cnt;
  logic memreq_prev;

  ics_sample_server_if ifa ();
  ics_sample_server_if ifb ();

  ics_sample_server #(.BASE_ADDR(29'h0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(rst_n), .bus(ifa)
  );

  ics_sample_server #(.BASE_ADDR(29'h1FFFFFF8), .TIMEOUT_CYCLES(256)) dut_b (
    .clk(clk), .reset_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ready pulses and mem_req rising edges of the main instance.
  always @(negedge clk) begin
    if (ifa.rsp_ready) rdy_cnt++;
    if (ifa.mem_req && !memreq_prev) memreq_cnt++;
    memreq_prev = ifa.mem_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_miss(input logic [28:0] addr, input logic [28:0] exp_maddr,
                          input int ack_dly, input int rv_dly, input logic [63:0] data,
                          input logic inv_req, input logic inv_rv, input int hold,
                          input string tag);
    int r0;
    int m0;
    r0 = rdy_cnt;
    m0 = memreq_cnt;
    ifa.req_rd    = 1'b1;
    ifa.req_addr  = addr;
    ifa.cache_inv = inv_req;
    step();
    ifa.cache_inv = 1'b0;
    check_eq({tag, ".mem_req"}, 64'(ifa.mem_req), 64'd1);
    check_eq({tag, ".mem_addr"}, 64'(ifa.mem_addr), 64'(exp_maddr));
    ifa.req_addr = ~addr;
    repeat (ack_dly) step();
    ifa.mem_ack = 1'b1;
    step();
    ifa.mem_ack = 1'b0;
    check_eq({tag, ".req_drop"}, 64'(ifa.mem_req), 64'd0);
    repeat (rv_dly - 1) step();
    ifa.mem_rvalid = 1'b1;
    ifa.mem_rdata  = data;
    ifa.cache_inv  = inv_rv;
    step();
    ifa.mem_rvalid = 1'b0;
    ifa.mem_rdata  = 64'h0;
    ifa.cache_inv  = 1'b0;
    check_eq({tag, ".ready"}, 64'(ifa.rsp_ready), 64'd1);
    check_eq({tag, ".data"}, ifa.rsp_data, data);
    repeat (hold) step();
    if (hold > 0) check_eq({tag, ".busy_hold"}, 64'(ifa.rsp_busy), 64'd1);
    ifa.req_rd = 1'b0;
    if (hold == 0) step();
    step();
    check_eq({tag, ".idle"}, 64'(ifa.rsp_busy), 64'd0);
    check_eq({tag, ".n_ready"}, 64'(rdy_cnt - r0), 64'd1);
    check_eq({tag, ".n_mreq"}, 64'(memreq_cnt - m0), 64'd1);
  endtask

  task automatic run_hit(input logic [28:0] addr, input logic [63:0] data, input string tag);
    int r0;
    int m0;
    r0 = rdy_cnt;
    m0 = memreq_cnt;
    ifa.req_rd   = 1'b1;
    ifa.req_addr = addr;
    step();
    check_eq({tag, ".ready"}, 64'(ifa.rsp_ready), 64'd1);
    check_eq({tag, ".data"}, ifa.rsp_data, data);
    ifa.req_rd = 1'b0;
    step();
    step();
    check_eq({tag, ".idle"}, 64'(ifa.rsp_busy), 64'd0);
    check_eq({tag, ".n_ready"}, 64'(rdy_cnt - r0), 64'd1);
    check_eq({tag, ".n_mreq"}, 64'(memreq_cnt - m0), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".rsp_data"}, ifa.rsp_data, 64'h0);
    check_eq({tag, ".rsp_ready"}, 64'(ifa.rsp_ready), 64'd0);
    check_eq({tag, ".rsp_busy"}, 64'(ifa.rsp_busy), 64'd0);
    check_eq({tag, ".mem_req"}, 64'(ifa.mem_req), 64'd0);
    check_eq({tag, ".mem_addr"}, 64'(ifa.mem_addr), 64'd0);
    check_eq({tag, ".timeout_err"}, 64'(ifa.timeout_err), 64'd0);
  endtask

  initial begin
    int r0;
    n_checks = 0;  n_errors = 0;
    rdy_cnt = 0;   memreq_cnt = 0; memreq_prev = 1'b0;
    rst_n = 1'b0;
    ifa.req_rd = 1'b0; ifa.req_addr = 29'h0; ifa.mem_ack = 1'b0;
    ifa.mem_rdata = 64'h0; ifa.mem_rvalid = 1'b0; ifa.cache_inv = 1'b0;
    ifb.req_rd = 1'b0; ifb.req_addr = 29'h0; ifb.mem_ack = 1'b0;
    ifb.mem_rdata = 64'h0; ifb.mem_rvalid = 1'b0; ifb.cache_inv = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Miss then same-word hit.
    run_miss(29'h000123, 29'h000120, 2, 3, 64'h0123456789ABCDEF, 1'b0, 1'b0, 0, "miss1");
    run_hit(29'h000125, 64'h0123456789ABCDEF, "hit1");

    // Offset wrap on the second instance.
    ifb.req_rd   = 1'b1;
    ifb.req_addr = 29'h10;
    step();
    check_eq("wrap.mem_req", 64'(ifb.mem_req), 64'd1);
    check_eq("wrap.mem_addr", 64'(ifb.mem_addr), 64'h8);
    ifb.mem_ack = 1'b1;
    step();
    ifb.mem_ack    = 1'b0;
    ifb.mem_rvalid = 1'b1;
    ifb.mem_rdata  = 64'hA5A5_0000_1111_2222;
    step();
    ifb.mem_rvalid = 1'b0;
    check_eq("wrap.ready", 64'(ifb.rsp_ready), 64'd1);
    check_eq("wrap.data", ifb.rsp_data, 64'hA5A5_0000_1111_2222);
    ifb.req_rd = 1'b0;
    step();
    step();
    check_eq("wrap.idle", 64'(ifb.rsp_busy), 64'd0);

    // Timeout: 8 WAIT cycles without rvalid.
    ifa.req_rd   = 1'b1;
    ifa.req_addr = 29'h200;
    step();
    check_eq("to.mem_req", 64'(ifa.mem_req), 64'd1);
    ifa.mem_ack = 1'b1;
    step();
    ifa.mem_ack = 1'b0;
    r0 = rdy_cnt;
    repeat (7) step();
    check_eq("to.early_ready", 64'(rdy_cnt - r0), 64'd0);
    check_eq("to.err_early", 64'(ifa.timeout_err), 64'd0);
    step();
    check_eq("to.ready", 64'(ifa.rsp_ready), 64'd1);
    check_eq("to.data", ifa.rsp_data, 64'h0);
    check_eq("to.err", 64'(ifa.timeout_err), 64'd1);
    ifa.req_rd = 1'b0;
    step();
    step();
    check_eq("to.err_sticky", 64'(ifa.timeout_err), 64'd1);
    run_miss(29'h200, 29'h200, 0, 1, 64'hDEAD_BEEF_0000_0200, 1'b0, 1'b0, 0, "to_retry");
    check_eq("to.err_after", 64'(ifa.timeout_err), 64'd1);

    // Invalidate in idle, on the fill cycle, and on the hit check.
    run_miss(29'h40, 29'h40, 1, 2, 64'h4040_4040_0000_0001, 1'b0, 1'b0, 0, "fill40");
    run_hit(29'h44, 64'h4040_4040_0000_0001, "hit40");
    ifa.cache_inv = 1'b1;
    step();
    ifa.cache_inv = 1'b0;
    run_miss(29'h40, 29'h40, 0, 1, 64'h4040_4040_0000_0002, 1'b0, 1'b1, 0, "inv_rv");
    run_miss(29'h40, 29'h40, 1, 1, 64'h4040_4040_0000_0003, 1'b0, 1'b0, 0, "after_inv_rv");
    run_hit(29'h47, 64'h4040_4040_0000_0003, "hit40b");
    run_miss(29'h40, 29'h40, 0, 2, 64'h4040_4040_0000_0004, 1'b1, 1'b0, 0, "inv_hit");

    // Request held for 5 cycles after the ready pulse.
    run_miss(29'h300, 29'h300, 1, 2, 64'h3030_3030_3030_3030, 1'b0, 1'b0, 5, "held");

    // Reset in the middle of WAIT, then a stray rvalid.
    r0 = rdy_cnt;
    ifa.req_rd   = 1'b1;
    ifa.req_addr = 29'h400;
    step();
    ifa.mem_ack = 1'b1;
    step();
    ifa.mem_ack = 1'b0;
    step();
    rst_n      = 1'b0;
    ifa.req_rd = 1'b0;
    #2;
    check_outputs_zero("rst_async");
    step();
    rst_n = 1'b1;
    step();
    ifa.mem_rvalid = 1'b1;
    ifa.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    ifa.mem_rvalid = 1'b0;
    ifa.mem_rdata  = 64'h0;
    step();
    check_outputs_zero("rst_stray");
    check_eq("rst.n_ready", 64'(rdy_cnt - r0), 64'd0);
    run_miss(29'h300, 29'h300, 0, 1, 64'h0000_0000_0000_0300, 1'b0, 1'b0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
